// File: rtl/if_stage_if.sv
// Instruction-memory fetch channel: a valid/ready request carrying a byte address, and an in-order response.
// Latency: none. This file holds wiring only.
// Backpressure: req_ready stalls requests. Responses are never back-pressured.
// Signals: req_valid/req_addr (fetch -> mem), req_ready (mem -> fetch),
//          rsp_valid/rsp_data (mem -> fetch, in request order).
interface if_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches words into a DEPTH-entry prefetch queue, and presents {instr, pc+4}.
// Latency: a request accepted at edge T returns in cycle T+1 on 1-cycle memory. It is presented in cycle T+2.
// Backpressure: requests stop once the queued plus in-flight count reaches DEPTH. freeze holds the head entry.
// Ports: clk, rst (async active-low), freeze, branch_taken/branch_addr (redirect),
//        imem (fetch channel, master side), if_valid/instruction/pc_out (to the IF/ID register).
module if_stage #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  if_stage_if.master  imem,
  output logic        if_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_out
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   pc;       // next fetch address
  logic [31:0]   rsp_pc;   // address of the next response that will be kept
  logic [CW-1:0] occ;
  logic [CW-1:0] outst;
  logic [CW-1:0] drop;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   q_pc4   [DEPTH];
  logic [31:0]   q_instr [DEPTH];

  logic          pop;
  logic          req_fire;
  logic          rsp_any;
  logic          rsp_take;
  logic [CW:0]   credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign if_valid = (occ != '0);
  assign pop      = if_valid && !freeze;

  // Counting the head being popped this cycle as freed keeps a back-to-back stream at one word per cycle.
  assign credit_used    = {1'b0, occ} + {1'b0, outst} - {{CW{1'b0}}, pop};
  assign imem.req_valid = rst && !branch_taken && (credit_used < (CW+1)'(DEPTH));
  assign imem.req_addr  = pc;
  assign req_fire       = imem.req_valid && imem.req_ready;

  // A response with nothing accounted for is stray and is ignored entirely.
  assign rsp_any  = imem.rsp_valid && ((outst != '0) || (drop != '0));
  assign rsp_take = imem.rsp_valid && (drop == '0) && (outst != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= RESET_PC;
      rsp_pc <= RESET_PC;
      occ    <= '0;
      outst  <= '0;
      drop   <= '0;
      head   <= '0;
      tail   <= '0;
    end else if (branch_taken) begin
      pc     <= branch_addr;
      rsp_pc <= branch_addr;
      occ    <= '0;
      head   <= '0;
      tail   <= '0;
      outst  <= '0;
      // Every in-flight fetch becomes stale. A response arriving now is consumed here,
      // whether it would have been kept or dropped.
      drop   <= drop + outst - CW'(rsp_any);
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      if (rsp_take) begin
        rsp_pc <= rsp_pc + 32'd4;
        tail   <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      occ   <= occ + CW'(rsp_take) - CW'(pop);
      outst <= outst + CW'(req_fire) - CW'(rsp_take);
      if (imem.rsp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  // Queue storage needs no reset, because the outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (rsp_take && !branch_taken) begin
      q_pc4[tail]   <= rsp_pc + 32'd4;
      q_instr[tail] <= imem.rsp_data;
    end
  end

  assign instruction = if_valid ? q_instr[head] : 32'h0;
  assign pc_out      = if_valid ? q_pc4[head]   : 32'h0;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. The memory model returns data equal to the address, with a configurable latency.
// Inputs change 1ns after the rising edge. Outputs are checked at the falling edge.
module tb_if_stage;
  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        if_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;

  if_stage_if mem ();

  if_stage #(.DEPTH(2), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (mem),
    .if_valid     (if_valid),
    .instruction  (instruction),
    .pc_out       (pc_out)
  );

  int n_tests;
  int n_fail;
  int lat;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Handshake sampled just before each rising edge.
  logic        hs_s;
  logic [31:0] ha_s;
  initial begin
    hs_s = 1'b0;
    ha_s = 32'h0;
    forever begin
      @(negedge clk);
      #4;
      hs_s = rst && mem.req_valid && mem.req_ready;
      ha_s = mem.req_addr;
    end
  end

  // In-order memory, reset by the same rst.
  typedef struct {
    logic [31:0] addr;
    int          rem;
  } mreq_t;
  mreq_t mq[$];

  initial begin
    mem.rsp_valid = 1'b0;
    mem.rsp_data  = 32'h0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        mem.rsp_valid = 1'b0;
        mem.rsp_data  = 32'h0;
      end else begin
        #1;
        foreach (mq[i]) mq[i].rem--;
        if (hs_s) mq.push_back('{ha_s, lat - 1});
        if (mq.size() > 0 && mq[0].rem <= 0) begin
          mem.rsp_valid = 1'b1;
          mem.rsp_data  = mq[0].addr;
          void'(mq.pop_front());
        end else begin
          mem.rsp_valid = 1'b0;
          mem.rsp_data  = 32'h0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc4);
    check({tag, ".if_valid"}, 32'(if_valid), 32'(v));
    check({tag, ".instruction"}, instruction, ins);
    check({tag, ".pc_out"}, pc_out, pc4);
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] addr);
    check({tag, ".req_valid"}, 32'(mem.req_valid), 32'(v));
    check({tag, ".req_addr"}, mem.req_addr, addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns into cycle 0, the first cycle after reset release.
  task automatic restart(input int l);
    tick();
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = 32'h0;
    mem.req_ready = 1'b1;
    lat = l;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = 32'h0;
    mem.req_ready = 1'b1;
    lat = 1;

    // Reset state
    #2;
    chk_head("rst", 1'b0, 32'h0, 32'h0);
    chk_req("rst", 1'b0, 32'h0);

    // Stream from reset, 1-cycle memory
    tick(); tick(); rst = 1'b1;
    #4 chk_head("s0", 1'b0, 32'h0, 32'h0); chk_req("s0", 1'b1, 32'h0);
    tick(); #4 chk_head("s1", 1'b0, 32'h0, 32'h0); chk_req("s1", 1'b1, 32'h4);
    tick(); #4 chk_head("s2", 1'b1, 32'h0, 32'h4);
    tick(); #4 chk_head("s3", 1'b1, 32'h4, 32'h8);

    // Freeze for three cycles while instruction=8
    tick(); freeze = 1'b1;
    #4 chk_head("f0", 1'b1, 32'h8, 32'hC); chk_req("f0", 1'b0, 32'h10);
    tick(); #4 chk_head("f1", 1'b1, 32'h8, 32'hC); chk_req("f1", 1'b0, 32'h10);
    tick(); #4 chk_head("f2", 1'b1, 32'h8, 32'hC); chk_req("f2", 1'b0, 32'h10);
    tick(); freeze = 1'b0;
    #4 chk_head("r0", 1'b1, 32'h8, 32'hC); chk_req("r0", 1'b1, 32'h10);
    tick(); #4 chk_head("r1", 1'b1, 32'hC, 32'h10);
    tick(); #4 chk_head("r2", 1'b1, 32'h10, 32'h14);
    tick(); #4 chk_head("r3", 1'b1, 32'h14, 32'h18);

    // Branch with two fetches in flight, 3-cycle memory
    restart(3);
    #4 chk_req("b0", 1'b1, 32'h0);
    tick(); #4 chk_req("b1", 1'b1, 32'h4);
    tick(); branch_taken = 1'b1; branch_addr = 32'h100;
    #4 chk_req("b2", 1'b0, 32'h8);
    tick(); branch_taken = 1'b0;
    #4 chk_head("b3", 1'b0, 32'h0, 32'h0); chk_req("b3", 1'b1, 32'h100);
    tick(); #4 chk_head("b4", 1'b0, 32'h0, 32'h0); chk_req("b4", 1'b1, 32'h104);
    tick(); #4 chk_head("b5", 1'b0, 32'h0, 32'h0); chk_req("b5", 1'b0, 32'h108);
    tick(); #4 chk_head("b6", 1'b0, 32'h0, 32'h0);
    tick(); #4 chk_head("b7", 1'b1, 32'h100, 32'h104); chk_req("b7", 1'b1, 32'h108);
    tick(); #4 chk_head("b8", 1'b1, 32'h104, 32'h108);

    // Request backpressure: ready 1,0,0,1
    restart(1);
    #4 chk_req("p0", 1'b1, 32'h0);
    tick(); mem.req_ready = 1'b0;
    #4 chk_req("p1", 1'b1, 32'h4);
    tick(); #4 chk_req("p2", 1'b1, 32'h4); chk_head("p2", 1'b1, 32'h0, 32'h4);
    tick(); mem.req_ready = 1'b1;
    #4 chk_req("p3", 1'b1, 32'h4); chk_head("p3", 1'b0, 32'h0, 32'h0);
    tick(); #4 chk_req("p4", 1'b1, 32'h8); chk_head("p4", 1'b0, 32'h0, 32'h0);
    tick(); #4 chk_head("p5", 1'b1, 32'h4, 32'h8);
    tick(); #4 chk_head("p6", 1'b1, 32'h8, 32'hC);

    // Address wrap, then a branch in the same cycle as a response
    restart(1);
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFF8;
    #4 chk_req("w0", 1'b0, 32'h0);
    tick(); branch_taken = 1'b0;
    #4 chk_req("w1", 1'b1, 32'hFFFF_FFF8);
    tick(); #4 chk_req("w2", 1'b1, 32'hFFFF_FFFC);
    tick(); #4 chk_head("w3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC); chk_req("w3", 1'b1, 32'h0);
    tick(); branch_taken = 1'b1; branch_addr = 32'h200;
    #4 chk_head("w4", 1'b1, 32'hFFFF_FFFC, 32'h0); chk_req("w4", 1'b0, 32'h4);
    tick(); branch_taken = 1'b0;
    #4 chk_head("w5", 1'b0, 32'h0, 32'h0); chk_req("w5", 1'b1, 32'h200);
    tick(); #4 chk_head("w6", 1'b0, 32'h0, 32'h0); chk_req("w6", 1'b1, 32'h204);
    tick(); #4 chk_head("w7", 1'b1, 32'h200, 32'h204);

    // Reset pulse of half a cycle during streaming
    restart(1);
    tick(); tick(); tick();
    #4 chk_head("m3", 1'b1, 32'h4, 32'h8);
    tick();
    #1 rst = 1'b0;
    #1 chk_head("mr", 1'b0, 32'h0, 32'h0); chk_req("mr", 1'b0, 32'h0);
    #4 rst = 1'b1;
    #1 chk_head("m0", 1'b0, 32'h0, 32'h0); chk_req("m0", 1'b1, 32'h0);
    tick(); #4 chk_head("m1", 1'b0, 32'h0, 32'h0); chk_req("m1", 1'b1, 32'h4);
    tick(); #4 chk_head("m2", 1'b1, 32'h0, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
